// File: rtl/instr_fetch_if.sv
// Fetch-stage bus bundle: instruction-memory request/response, execute
// redirect, and the instruction handshake towards decode.
//
// Handshake rules for every valid/ready pair in this bundle:
//   a transfer happens in a cycle where valid && ready on the rising clock
//   edge; the producer may lower valid without a transfer only where the
//   fetch stage allows it (redirect, full output buffer); payload is held
//   stable while valid && !ready. The memory response has no ready and is
//   always accepted.
interface instr_fetch_if #(
    parameter int XLEN = 64
);
    // instruction-memory request channel
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;

    // instruction-memory response channel
    logic            imem_resp_valid;
    logic [31:0]     imem_resp_data;

    // redirect from execute
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;

    // instruction channel towards decode/control
    logic            inst_valid;
    logic            inst_ready;
    logic [31:0]     inst;
    logic [XLEN-1:0] inst_pc;
    logic [6:0]      inst_opcode;

    // fetch stage side
    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_resp_valid,
        input  imem_resp_data,
        input  redirect_valid,
        input  redirect_pc,
        output inst_valid,
        output inst,
        output inst_pc,
        output inst_opcode,
        input  inst_ready
    );

    // environment side: memory, execute and decode
    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_resp_valid,
        output imem_resp_data,
        output redirect_valid,
        output redirect_pc,
        input  inst_valid,
        input  inst,
        input  inst_pc,
        input  inst_opcode,
        output inst_ready
    );

endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, keeps at most one request in flight
// to instruction memory and hands fetched words to decode through a
// one-entry output buffer. A redirect restarts fetch at a new PC; a request
// already in flight at that point is drained and its data thrown away.
module instr_fetch #(
    parameter int              XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    instr_fetch_if.master fetch_if,
    output logic [1:0]    dbg_state_o
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_REQ   = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    logic [1:0]      state_q,     state_d;
    logic [XLEN-1:0] pc_q,        pc_d;
    logic [XLEN-1:0] req_pc_q,    req_pc_d;
    logic            buf_valid_q, buf_valid_d;
    logic [31:0]     inst_q,      inst_d;
    logic [XLEN-1:0] inst_pc_q,   inst_pc_d;

    logic            req_valid;
    logic            req_fire;
    logic            out_fire;
    logic            buf_free;
    logic            in_flight;
    logic [XLEN-1:0] redirect_target;

    // The low redirect bits are dropped on purpose; instructions are word aligned.
    logic unused_redirect_lsbs;
    assign unused_redirect_lsbs = ^fetch_if.redirect_pc[1:0];

    assign redirect_target = {fetch_if.redirect_pc[XLEN-1:2], 2'b00};

    // Decode takes the buffered instruction this cycle.
    assign out_fire = buf_valid_q && fetch_if.inst_ready;

    // Slot is free at issue time if empty or emptied this cycle, so the
    // eventual response always has a place to land.
    assign buf_free = !buf_valid_q || fetch_if.inst_ready;

    // Request valid depends only on registered state and inst_ready, never on
    // imem_req_ready.
    assign req_valid = (state_q == ST_REQ) && buf_free;
    assign req_fire  = req_valid && fetch_if.imem_req_ready;

    // A request stays outstanding past this cycle if we are waiting/draining
    // and no response arrives, or if one is being issued right now.
    assign in_flight = (((state_q == ST_WAIT) || (state_q == ST_DRAIN))
                        && !fetch_if.imem_resp_valid)
                       || req_fire;

    // Next-state logic: normal sequencing first, redirect overrides last.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        req_pc_d    = req_pc_q;
        buf_valid_d = buf_valid_q;
        inst_d      = inst_q;
        inst_pc_d   = inst_pc_q;

        if (out_fire) begin
            buf_valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                state_d = ST_REQ;
            end
            ST_REQ: begin
                if (req_fire) begin
                    req_pc_d = pc_q;
                    pc_d     = pc_q + XLEN'(4);
                    state_d  = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (fetch_if.imem_resp_valid) begin
                    buf_valid_d = 1'b1;
                    inst_d      = fetch_if.imem_resp_data;
                    inst_pc_d   = req_pc_q;
                    state_d     = ST_REQ;
                end
            end
            ST_DRAIN: begin
                // Squashed request: its response is consumed and dropped.
                if (fetch_if.imem_resp_valid) begin
                    state_d = ST_REQ;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (fetch_if.redirect_valid) begin
            pc_d        = redirect_target;
            buf_valid_d = 1'b0;
            // inst/inst_pc keep their old contents; only the valid bit matters.
            inst_d      = inst_q;
            inst_pc_d   = inst_pc_q;
            state_d     = in_flight ? ST_DRAIN : ST_REQ;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            pc_q        <= RESET_PC;
            req_pc_q    <= '0;
            buf_valid_q <= 1'b0;
            inst_q      <= '0;
            inst_pc_q   <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            req_pc_q    <= req_pc_d;
            buf_valid_q <= buf_valid_d;
            inst_q      <= inst_d;
            inst_pc_q   <= inst_pc_d;
        end
    end

    assign fetch_if.imem_req_valid = req_valid;
    assign fetch_if.imem_req_addr  = pc_q;
    assign fetch_if.inst_valid     = buf_valid_q;
    assign fetch_if.inst           = inst_q;
    assign fetch_if.inst_pc        = inst_pc_q;
    assign fetch_if.inst_opcode    = inst_q[6:0];

    assign dbg_state_o = state_q;

endmodule
